ntoe_game_ctrl: RTL and testbench



---
 rtl/ntoe_pkg.sv | 28 ++
 rtl/ntoe_win_detect.sv | 39 +++
 rtl/ntoe_game_ctrl.sv | 157 +++++++++++++++
 tb/tb_ntoe_game_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ntoe_pkg.sv
// Shared types for the N-in-a-row game controller: cell codes, winner codes, FSM states.
package ntoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        WIN_P1 = 2'b01,
        WIN_P2 = 2'b10,
        DRAW   = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Mark written by the player whose turn it is (turn 0 -> P1, turn 1 -> P2).
    function automatic logic [1:0] mark_of(input logic turn);
        return turn ? P2 : P1;
    endfunction

endpackage

// File: rtl/ntoe_win_detect.sv
// Combinational line/full detector over an N x N board for a given mover code.
module ntoe_win_detect
    import ntoe_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [2*N*N-1:0] board_i,
    input  logic [1:0]       mover_i,
    output logic             line_hit_o,
    output logic             full_o
);

    // Scan every row, column and both main diagonals for a complete line, and all cells for EMPTY.
    always_comb begin
        logic row_ok, col_ok, d0_ok, d1_ok;
        line_hit_o = 1'b0;
        full_o     = 1'b1;
        row_ok     = 1'b0;
        col_ok     = 1'b0;
        d0_ok      = 1'b1;
        d1_ok      = 1'b1;
        for (int i = 0; i < N*N; i++) begin
            if (board_i[2*i +: 2] == EMPTY) full_o = 1'b0;
        end
        for (int r = 0; r < N; r++) begin
            row_ok = 1'b1;
            col_ok = 1'b1;
            for (int c = 0; c < N; c++) begin
                if (board_i[2*(r*N+c) +: 2] != mover_i) row_ok = 1'b0;
                if (board_i[2*(c*N+r) +: 2] != mover_i) col_ok = 1'b0;
            end
            if (row_ok || col_ok) line_hit_o = 1'b1;
            if (board_i[2*(r*N+r) +: 2] != mover_i)         d0_ok = 1'b0;
            if (board_i[2*(r*N+(N-1-r)) +: 2] != mover_i)   d1_ok = 1'b0;
        end
        if (d0_ok || d1_ok) line_hit_o = 1'b1;
    end

endmodule

// File: rtl/ntoe_game_ctrl.sv
// N x N N-in-a-row game controller: input edge detect, cursor search, move timer and PLAY/CHECK/DONE FSM.
module ntoe_game_ctrl
    import ntoe_pkg::*;
#(
    parameter int N       = 3,
    parameter int TIMEOUT = 0,
    parameter int TW      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel,
    input  logic                     next,
    output logic [2*N*N-1:0]         board,
    output logic [$clog2(N*N)-1:0]   cursor,
    output logic                     turn,
    output logic [1:0]               winner,
    output logic                     game_over
);

    localparam int NN = N*N;
    localparam int CW = $clog2(NN);

    state_t           state_q, state_d;
    logic [2*NN-1:0]  board_q, board_d;
    logic [CW-1:0]    cursor_q, cursor_d;
    logic             turn_q, turn_d;
    logic [1:0]       winner_q, winner_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             sel_q, next_q;

    logic             sel_rise, next_rise;
    logic             cur_empty, tmo_hit;
    logic [CW-1:0]    low_idx, next_idx, auto_idx;
    logic [1:0]       mark;
    logic             line_hit, full;

    assign sel_rise  = sel & ~sel_q;
    assign next_rise = next & ~next_q;
    assign mark      = mark_of(turn_q);
    assign cur_empty = (board_q[2*int'(cursor_q) +: 2] == EMPTY);
    assign tmo_hit   = (TIMEOUT > 0) && (timer_q == TW'(TIMEOUT - 1));
    assign auto_idx  = cur_empty ? cursor_q : low_idx;

    ntoe_win_detect #(.N(N)) u_win (
        .board_i    (board_q),
        .mover_i    (mark),
        .line_hit_o (line_hit),
        .full_o     (full)
    );

    // Lowest empty index (0 if the board is full; that case never reaches PLAY).
    always_comb begin
        low_idx = '0;
        for (int i = NN-1; i >= 0; i--) begin
            if (board_q[2*i +: 2] == EMPTY) low_idx = CW'(i);
        end
    end

    // First empty index strictly above the cursor, wrapping modulo N*N; stays put if none.
    always_comb begin
        logic found;
        int   idx;
        next_idx = cursor_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k < NN; k++) begin
            idx = (int'(cursor_q) + k) % NN;
            if (!found && board_q[2*idx +: 2] == EMPTY) begin
                next_idx = CW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Next-state logic: placement/timeout/cursor in PLAY, evaluation in CHECK, restart in DONE.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        timer_d  = timer_q;
        case (state_q)
            PLAY: begin
                if (sel_rise && cur_empty) begin
                    board_d[2*int'(cursor_q) +: 2] = mark;
                    timer_d = '0;
                    state_d = CHECK;
                end else if (tmo_hit) begin
                    // A stalled player gets a mark at the cursor, or the lowest free cell.
                    board_d[2*int'(auto_idx) +: 2] = mark;
                    timer_d = '0;
                    state_d = CHECK;
                end else begin
                    if (TIMEOUT > 0) timer_d = timer_q + 1'b1;
                    if (next_rise && !sel_rise) cursor_d = next_idx;
                end
            end
            CHECK: begin
                // Win is tested before full so a board-filling winning move is a win.
                if (line_hit) begin
                    winner_d = turn_q ? WIN_P2 : WIN_P1;
                    state_d  = DONE;
                end else if (full) begin
                    winner_d = DRAW;
                    state_d  = DONE;
                end else begin
                    turn_d   = ~turn_q;
                    cursor_d = low_idx;
                    timer_d  = '0;
                    state_d  = PLAY;
                end
            end
            DONE: begin
                if (next_rise) begin
                    board_d  = '0;
                    winner_d = NONE;
                    turn_d   = 1'b0;
                    cursor_d = '0;
                    timer_d  = '0;
                    state_d  = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // State and edge-detect registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PLAY;
            board_q  <= '0;
            cursor_q <= '0;
            turn_q   <= 1'b0;
            winner_q <= NONE;
            timer_q  <= '0;
            sel_q    <= 1'b0;
            next_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cursor_q <= cursor_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            timer_q  <= timer_d;
            sel_q    <= sel;
            next_q   <= next;
        end
    end

    assign board     = board_q;
    assign cursor    = cursor_q;
    assign turn      = turn_q;
    assign winner    = winner_q;
    assign game_over = (state_q == DONE);

endmodule

// File: tb/tb_ntoe_game_ctrl.sv
// Directed bench: a 3x3 untimed instance and a 4x4 instance with a 10-cycle move timeout.
module tb_ntoe_game_ctrl;

    logic        clk = 1'b0;
    logic        rst3, sel3, next3, rst4, sel4, next4;
    logic [17:0] board3;
    logic [3:0]  cursor3;
    logic        turn3, go3;
    logic [1:0]  winner3;
    logic [31:0] board4;
    logic [3:0]  cursor4;
    logic        turn4, go4;
    logic [1:0]  winner4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ntoe_game_ctrl #(.N(3), .TIMEOUT(0), .TW(32)) dut3 (
        .clk(clk), .rst(rst3), .sel(sel3), .next(next3),
        .board(board3), .cursor(cursor3), .turn(turn3), .winner(winner3), .game_over(go3)
    );

    ntoe_game_ctrl #(.N(4), .TIMEOUT(10), .TW(8)) dut4 (
        .clk(clk), .rst(rst4), .sel(sel4), .next(next4),
        .board(board4), .cursor(cursor4), .turn(turn4), .winner(winner4), .game_over(go4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_next3();
        next3 = 1'b1; step();
        next3 = 1'b0; step();
    endtask

    task automatic place3();
        sel3 = 1'b1; step();
        sel3 = 1'b0; step();
    endtask

    task automatic reset3();
        rst3 = 1'b1; step();
        rst3 = 1'b0; step();
    endtask

    // Walk the cursor to a target cell with a bounded number of next presses.
    task automatic move_to(input int idx);
        for (int k = 0; k < 12 && int'(cursor3) != idx; k++) press_next3();
        chk("move_to", 32'(cursor3), 32'(idx));
    endtask

    initial begin
        int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        rst3 = 1'b1; sel3 = 1'b0; next3 = 1'b0;
        rst4 = 1'b1; sel4 = 1'b0; next4 = 1'b0;
        step(); step();
        chk("rst_board",  32'(board3),  32'h0);
        chk("rst_cursor", 32'(cursor3), 32'h0);
        chk("rst_turn",   32'(turn3),   32'h0);
        chk("rst_winner", 32'(winner3), 32'h0);
        chk("rst_go",     32'(go3),     32'h0);
        rst3 = 1'b0; step();

        // Held sel: one mark, then turn/cursor update after CHECK
        sel3 = 1'b1; step();
        chk("t1_mark", 32'(board3), 32'h1);
        step();
        chk("t1_board_chk", 32'(board3),  32'h1);
        chk("t1_turn",      32'(turn3),   32'h1);
        chk("t1_cursor",    32'(cursor3), 32'h1);
        step();
        chk("t1_held", 32'(board3), 32'h1);
        sel3 = 1'b0; step();

        // P1 wins the top row
        reset3();
        move_to(0); place3();
        move_to(3); place3();
        move_to(1); place3();
        move_to(4); place3();
        chk("t2_nowin", 32'(winner3), 32'h0);
        move_to(2); place3();
        chk("t2_winner", 32'(winner3), 32'h1);
        chk("t2_go",     32'(go3),     32'h1);
        chk("t2_board",  32'(board3),  32'h295);
        place3();
        chk("t2_sel_ign", 32'(board3),  32'h295);
        chk("t2_win_kept", 32'(winner3), 32'h1);
        press_next3();
        chk("t2_rs_board",  32'(board3),  32'h0);
        chk("t2_rs_winner", 32'(winner3), 32'h0);
        chk("t2_rs_turn",   32'(turn3),   32'h0);
        chk("t2_rs_cursor", 32'(cursor3), 32'h0);
        chk("t2_rs_go",     32'(go3),     32'h0);

        // Cursor skipping and wrap
        place3();
        move_to(2); place3();
        chk("t3_cur_low", 32'(cursor3), 32'h1);
        press_next3();
        chk("t3_skip", 32'(cursor3), 32'h3);
        move_to(8);
        press_next3();
        chk("t3_wrap", 32'(cursor3), 32'h1);

        // Draw
        reset3();
        for (int m = 0; m < 8; m++) begin
            move_to(draw_seq[m]); place3();
        end
        chk("t4_nowin", 32'(winner3), 32'h0);
        move_to(draw_seq[8]); place3();
        chk("t4_board",  32'(board3),  32'h16A59);
        chk("t4_winner", 32'(winner3), 32'h3);
        chk("t4_go",     32'(go3),     32'h1);

        // Async reset during CHECK
        reset3();
        place3();
        sel3 = 1'b1; step();
        chk("t6_pre", 32'(board3), 32'h9);
        rst3 = 1'b1; #1;
        chk("t6_board",  32'(board3),  32'h0);
        chk("t6_winner", 32'(winner3), 32'h0);
        chk("t6_turn",   32'(turn3),   32'h0);
        chk("t6_cursor", 32'(cursor3), 32'h0);
        chk("t6_go",     32'(go3),     32'h0);
        sel3 = 1'b0; step();
        rst3 = 1'b0; step();

        // Timeout auto-place on the 4x4 instance
        rst4 = 1'b0;
        repeat (9) step();
        chk("t5_pre_tmo", 32'(board4), 32'h0);
        step();
        chk("t5_auto", 32'(board4), 32'h1);
        step();
        chk("t5_turn",   32'(turn4),   32'h1);
        chk("t5_cursor", 32'(cursor4), 32'h1);
        next4 = 1'b1; step();
        next4 = 1'b0; step();
        next4 = 1'b1; step();
        next4 = 1'b0; step();
        chk("t5_cur3", 32'(cursor4), 32'h3);
        repeat (5) step();
        chk("t5_pre_sel", 32'(board4), 32'h1);
        sel4 = 1'b1; step();
        chk("t5_sel_tmo", 32'(board4), 32'h81);
        step();
        chk("t5_one_mark", 32'(board4), 32'h81);
        chk("t5_turn2",    32'(turn4),  32'h0);
        sel4 = 1'b0; step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
